// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating the PmodJSTK joystick: returns a 5-byte position/button
// frame and decodes the master's LED command byte. Optional macro: JSTK_FRAME_ERR_EN.
module jstk_spi_responder #(
   parameter int NBYTES      = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       SS,
   input  logic       SCLK,
   input  logic       MOSI,
   output logic       MISO,
   output logic       miso_oe,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   input  logic [2:0] btn,
   output logic [1:0] led_out,
   output logic       frame_done,
   output logic       frame_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [2:0] NB_C    = 3'(NBYTES);
   localparam logic [5:0] LED_CMD = 6'b100000;

   // Byte of the captured frame at position idx; positions past the frame read as zero.
   function automatic logic [7:0] sel_byte(input logic [39:0] buf_v, input logic [2:0] idx);
      case (idx)
         3'd0:    return buf_v[7:0];
         3'd1:    return buf_v[15:8];
         3'd2:    return buf_v[23:16];
         3'd3:    return buf_v[31:24];
         3'd4:    return buf_v[39:32];
         default: return 8'h00;
      endcase
   endfunction

   logic [SYNC_STAGES-1:0] ss_sync_q;
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   ss_dly_q;
   logic                   sck_dly_q;

   logic ss_s;
   logic sck_s;
   logic mosi_s;
   logic ss_fall_s;
   logic ss_rise_s;
   logic sck_rise_s;
   logic sck_fall_s;

   state_t      state_q,    state_d;
   logic [2:0]  bit_cnt_q,  bit_cnt_d;
   logic [2:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [39:0] tx_buf_q,   tx_buf_d;
   logic        miso_q,     miso_d;
   logic        oe_q,       oe_d;
   logic [1:0]  led_q,      led_d;
   logic        done_q,     done_d;

   logic [7:0]  rx_next_s;
   logic [39:0] snap_s;
   logic [7:0]  next_byte_s;
   logic [7:0]  tx_shl_s;

   // Synchronizer chains, preset to the idle bus levels, plus one delayed copy for edge detection
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         ss_sync_q   <= '1;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         ss_dly_q    <= 1'b1;
         sck_dly_q   <= 1'b0;
      end else begin
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCLK};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
         ss_dly_q    <= ss_sync_q[SYNC_STAGES-1];
         sck_dly_q   <= sck_sync_q[SYNC_STAGES-1];
      end
   end

   assign ss_s       = ss_sync_q[SYNC_STAGES-1];
   assign sck_s      = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
   assign ss_fall_s  = ss_dly_q & ~ss_s;
   assign ss_rise_s  = ~ss_dly_q & ss_s;
   assign sck_rise_s = ~sck_dly_q & sck_s;
   assign sck_fall_s = sck_dly_q & ~sck_s;

   assign rx_next_s   = {rx_shift_q[6:0], mosi_s};
   assign snap_s      = {5'b00000, btn, 6'b000000, y_pos[9:8], y_pos[7:0],
                         6'b000000, x_pos[9:8], x_pos[7:0]};
   assign next_byte_s = sel_byte(tx_buf_q, byte_cnt_q);
   assign tx_shl_s    = {tx_shift_q[6:0], 1'b0};

   // Frame state register and datapath registers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 3'd0;
         rx_shift_q <= 8'h00;
         tx_shift_q <= 8'h00;
         tx_buf_q   <= 40'h0;
         miso_q     <= 1'b0;
         oe_q       <= 1'b0;
         led_q      <= 2'b00;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         tx_buf_q   <= tx_buf_d;
         miso_q     <= miso_d;
         oe_q       <= oe_d;
         led_q      <= led_d;
         done_q     <= done_d;
      end
   end

   // Next-state logic; ss_rise has priority over any SCLK edge seen in the same cycle
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      tx_buf_d   = tx_buf_q;
      miso_d     = miso_q;
      oe_d       = oe_q;
      led_d      = led_q;
      done_d     = 1'b0;

      if (ss_rise_s) begin
         state_d    = ST_IDLE;
         oe_d       = 1'b0;
         miso_d     = 1'b0;
         bit_cnt_d  = 3'd0;
         byte_cnt_d = 3'd0;
         done_d     = (state_q == ST_DONE);
      end else begin
         case (state_q)
            ST_IDLE: begin
               oe_d   = 1'b0;
               miso_d = 1'b0;
               if (ss_fall_s) begin
                  tx_buf_d   = snap_s;
                  tx_shift_d = snap_s[7:0];
                  miso_d     = snap_s[7];
                  oe_d       = 1'b1;
                  bit_cnt_d  = 3'd0;
                  byte_cnt_d = 3'd0;
                  state_d    = ST_ACTIVE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ACTIVE: begin
               oe_d = 1'b1;
               if (sck_rise_s) begin
                  rx_shift_d = rx_next_s;
                  if (bit_cnt_q == 3'd7) begin
                     bit_cnt_d  = 3'd0;
                     byte_cnt_d = byte_cnt_q + 3'd1;
                     if ((byte_cnt_q == 3'd0) && (rx_next_s[7:2] == LED_CMD)) begin
                        led_d = rx_next_s[1:0];
                     end else begin
                        led_d = led_q;
                     end
                     if ((byte_cnt_q + 3'd1) == NB_C) begin
                        state_d = ST_DONE;
                        miso_d  = 1'b0;
                     end else begin
                        state_d = ST_ACTIVE;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end else if (sck_fall_s) begin
                  // A fall right after a completed byte starts the next byte's MSB
                  if ((bit_cnt_q == 3'd0) && (byte_cnt_q != 3'd0)) begin
                     tx_shift_d = next_byte_s;
                     miso_d     = next_byte_s[7];
                  end else begin
                     tx_shift_d = tx_shl_s;
                     miso_d     = tx_shl_s[7];
                  end
               end else begin
                  state_d = ST_ACTIVE;
               end
            end
            ST_DONE: begin
               miso_d = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
               oe_d    = 1'b0;
               miso_d  = 1'b0;
            end
         endcase
      end
   end

   assign MISO       = miso_q;
   assign miso_oe    = oe_q;
   assign led_out    = led_q;
   assign frame_done = done_q;

`ifdef JSTK_FRAME_ERR_EN
   logic err_q, err_d;

   // Abort flag: deselect while bytes are still outstanding
   always_comb begin
      err_d = 1'b0;
      if (ss_rise_s && (state_q == ST_ACTIVE)) begin
         err_d = 1'b1;
      end else begin
         err_d = 1'b0;
      end
   end

   // Registered abort pulse
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign frame_err = err_q;
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: doc/jstk_spi_responder.md
Name: jstk_spi_responder

Overview:
- SPI slave that emulates the PmodJSTK joystick module. It is the responder end of the link driven by our joystick SPI master.
- Lets the game/movement path be exercised on the bench and on the board loopback (JA header) without the physical joystick.
- Returns a 5-byte position/button frame and decodes the master's LED command byte.

Parameters:
- NBYTES, 5, bytes per frame (fixed protocol length; supported values 1 to 5).
- SYNC_STAGES, 2, flops in each synchronizer for SS/SCLK/MOSI (minimum 2).

Ports:
- clk  input  1  system clock (100 MHz).
- clr  input  1  asynchronous active-low reset.
- SS  input  1  slave select from master, active-low.
- SCLK  input  1  SPI clock from master, mode 0 (idle low).
- MOSI  input  1  master-out data.
- MISO  output  1  slave-out data.
- miso_oe  output  1  1 while the frame is selected; external pad tri-states when 0.
- x_pos  input  10  emulated X position.
- y_pos  input  10  emulated Y position.
- btn  input  3  emulated buttons {btn2, btn1, trigger}.
- led_out  output  2  LED bits from the last valid command.
- frame_done  output  1  one-clk pulse when a complete frame ends.
- frame_err  output  1  one-clk pulse on an aborted frame (optional feature).

Behaviour:
- Reset (clr=0, any time, asynchronous):
  - MISO=0, miso_oe=0, led_out=2'b00, frame_done=0, frame_err=0.
  - bit_cnt=0, byte_cnt=0, state=IDLE.
  - Synchronizers preset to SS=1, SCLK=0, MOSI=0.
  - Reset mid-frame abandons the frame; no pulses are generated.
- Synchronization and edge detection:
  - SS, SCLK and MOSI each pass through SYNC_STAGES flops.
  - Edges (ss_fall, ss_rise, sck_rise, sck_fall) come from the last stage versus a one-cycle-delayed copy.
  - SCLK half-period must be at least SYNC_STAGES+2 clk cycles; shorter is outside spec.
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - miso_oe=0, MISO=0.
  - On ss_fall: snapshot x_pos, y_pos, btn into a 5-byte tx buffer.
    - byte0 = x[7:0]
    - byte1 = {6'b0, x[9:8]}
    - byte2 = y[7:0]
    - byte3 = {6'b0, y[9:8]}
    - byte4 = {5'b0, btn}
  - Load byte0 into tx_shift, drive MISO = byte0[7], go to ACTIVE. MISO is valid 1 clk after ss_fall is detected.
- ACTIVE:
  - miso_oe=1.
  - sck_rise: rx_shift <= {rx_shift[6:0], MOSI}; bit_cnt++.
  - When bit_cnt reaches 8: bit_cnt=0, byte_cnt++.
    - If it was byte 0 and the received byte[7:2]==6'b100000, then led_out <= received byte[1:0]. Any other byte0 leaves led_out unchanged.
    - If byte_cnt reaches NBYTES, go to DONE.
  - sck_fall: at a byte boundary (bit_cnt==0, after first byte), load tx buffer[byte_cnt] and drive its bit7. Otherwise shift tx_shift left, MISO = new bit7.
  - Input changes during the frame do not affect the snapshot.
- DONE:
  - MISO=0; extra SCLK edges are ignored and counters are held.
- ss_rise in any state:
  - Return to IDLE; miso_oe=0; bit_cnt=0, byte_cnt=0.
  - From DONE: frame_done=1 for exactly one clk.
  - From ACTIVE: frame is aborted, no frame_done. led_out keeps any update made at a completed byte 0.
- Simultaneous ss_rise and sck edge in the same clk: ss_rise wins and the sck edge is dropped.
- A SCLK edge while SS is high is ignored.

Optional Feature:
- Macro JSTK_FRAME_ERR_EN.
- Defined: frame_err pulses for one clk on ss_rise from ACTIVE, i.e. fewer than NBYTES complete bytes. This includes a partial byte and a zero-bit select.
- Undefined: frame_err is tied to 0, no extra logic. All other behaviour is identical.

Test Plan:
- Reset: hold clr=0 with SS toggling -> MISO=0, miso_oe=0, led_out=00, no pulses. Release -> state IDLE.
- Full frame: x_pos=10'h2A5, y_pos=10'h13C, btn=3'b101, master sends 8'h83 then 4x 8'h00 at 1 MHz SCLK. Expect:
  - MISO bytes A5, 02, 3C, 01, 05.
  - led_out=2'b11 after byte 0.
  - frame_done single pulse after SS rises.
- Snapshot hold: change x_pos to 10'h3FF after byte 1 -> frame still returns A5, 02. Next frame returns FF, 03.
- Non-command byte 0: master sends 8'h00 first -> led_out unchanged from prior value; frame_done still pulses.
- Abort: SS rises after 12 SCLK rises -> no frame_done; frame_err pulses with JSTK_FRAME_ERR_EN, stays 0 without. Next full frame is correct.
- Overrun: 48 SCLK cycles in one select -> MISO=0 after bit 40, counters hold, frame_done pulses once.
